// File: rtl/nrisc_ifetch_queue.sv
// nrisc_ifetch_queue: NRISC instruction-fetch controller with a DEPTH-entry prefetch queue.
// Owns the fetch PC, issues pipelined word reads on IDATA (req/gnt/rvalid) and presents
// the head instruction plus its PC to the core, which consumes, holds or redirects.
// Optional build macro NRISC_IFQ_BYPASS_EN: when the queue is empty, an accepted read
// response is forwarded combinationally to the core in the same cycle.
module nrisc_ifetch_queue #(
   parameter int              IW        = 16,
   parameter int              AW        = 16,
   parameter int              DEPTH     = 4,
   parameter logic [AW-1:0]   RESET_VEC = '0,
   parameter logic [IW-1:0]   NOP_WORD  = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         CORE_PC_ctrl,
   input  logic [AW-1:0]      CORE_target,
   output logic [IW-1:0]      CORE_InstructionIN,
   output logic [AW-1:0]      CORE_instr_pc,
   output logic               CORE_instr_valid,
   output logic [AW-1:0]      IDATA_addr,
   output logic               IDATA_req,
   input  logic               IDATA_gnt,
   input  logic [IW-1:0]      IDATA_CORE_out,
   input  logic               IDATA_rvalid
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int CW1 = CW + 1;
   // drop can exceed DEPTH after back-to-back redirects against a slow memory
   localparam int DW  = PW + 4;

   logic [AW-1:0] fpc;
   logic [IW-1:0] q_data  [DEPTH];
   logic [AW-1:0] q_pc    [DEPTH];
   logic [AW-1:0] tag_mem [DEPTH];
   logic [PW-1:0] q_rd, q_wr, t_rd, t_wr;
   logic [CW-1:0] count, outstanding;
   logic [DW-1:0] drop;

   logic redirect, issue, resp_live, resp_drop, q_empty, pop, push, byp;

   // issue credit, response classification and queue push/pop decisions
   always_comb begin
      redirect  = CORE_PC_ctrl[1];
      q_empty   = (count == '0);
      IDATA_req = rst && !redirect &&
                  (({1'b0, count} + {1'b0, outstanding}) < CW1'(DEPTH));
      IDATA_addr = fpc;
      issue     = IDATA_req && IDATA_gnt;
      resp_live = IDATA_rvalid && (drop == '0);
      resp_drop = IDATA_rvalid && (drop != '0);
      pop       = !redirect && (CORE_PC_ctrl == 2'b00) && !q_empty;
`ifdef NRISC_IFQ_BYPASS_EN
      byp       = !redirect && q_empty && resp_live;
      // a forwarded word consumed in the same cycle never enters the queue
      push      = !redirect && resp_live && !(byp && (CORE_PC_ctrl == 2'b00));
`else
      byp       = 1'b0;
      push      = !redirect && resp_live;
`endif
   end

   // head-of-queue presentation to the core, NOP_WORD / pc 0 when nothing is valid
   always_comb begin
      CORE_instr_valid   = !q_empty;
      CORE_InstructionIN = q_empty ? NOP_WORD : q_data[q_rd];
      CORE_instr_pc      = q_empty ? '0 : q_pc[q_rd];
      if (byp) begin
         CORE_instr_valid   = 1'b1;
         CORE_InstructionIN = IDATA_CORE_out;
         CORE_instr_pc      = tag_mem[t_rd];
      end
   end

   // fetch PC, pointers and occupancy counters; redirect outranks any push/pop
   always_ff @(posedge clk) begin
      if (!rst) begin
         fpc         <= RESET_VEC;
         q_rd        <= '0;
         q_wr        <= '0;
         t_rd        <= '0;
         t_wr        <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else if (redirect) begin
         fpc         <= CORE_PC_ctrl[0] ? RESET_VEC : CORE_target;
         q_rd        <= '0;
         q_wr        <= '0;
         t_rd        <= '0;
         t_wr        <= '0;
         count       <= '0;
         outstanding <= '0;
         // every read still in flight after this edge returns stale data
         drop        <= DW'(outstanding) + drop - DW'(IDATA_rvalid);
      end else begin
         if (issue) begin
            fpc  <= fpc + 1'b1;
            t_wr <= t_wr + 1'b1;
         end
         if (resp_live) t_rd <= t_rd + 1'b1;
         if (resp_drop) drop <= drop - 1'b1;
         if (push)      q_wr <= q_wr + 1'b1;
         if (pop)       q_rd <= q_rd + 1'b1;
         outstanding <= outstanding + CW'(issue) - CW'(resp_live);
         count       <= count + CW'(push) - CW'(pop);
      end
   end

   // storage arrays: tag of each issued read, then data+tag of each queued word
   always_ff @(posedge clk) begin
      if (rst && !redirect && issue) tag_mem[t_wr] <= fpc;
      if (rst && push) begin
         q_data[q_wr] <= IDATA_CORE_out;
         q_pc[q_wr]   <= tag_mem[t_rd];
      end
   end

   // issue credit must make a push into a full queue impossible
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) push |-> (count < CW'(DEPTH)));

endmodule

// File: tb/tb_nrisc_ifetch_queue.sv
// Bench for nrisc_ifetch_queue: randomized memory/core stimulus against a queue-based model.
module tb_nrisc_ifetch_queue;
   localparam int          DEPTH = 4;
   localparam logic [15:0] RVEC  = 16'h0000;
   localparam logic [15:0] NOP   = 16'hDEAD;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  CORE_PC_ctrl;
   logic [15:0] CORE_target;
   logic [15:0] CORE_InstructionIN;
   logic [15:0] CORE_instr_pc;
   logic        CORE_instr_valid;
   logic [15:0] IDATA_addr;
   logic        IDATA_req;
   logic        IDATA_gnt;
   logic [15:0] IDATA_CORE_out;
   logic        IDATA_rvalid;

   nrisc_ifetch_queue #(.IW(16), .AW(16), .DEPTH(DEPTH), .RESET_VEC(RVEC), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .CORE_PC_ctrl(CORE_PC_ctrl), .CORE_target(CORE_target),
      .CORE_InstructionIN(CORE_InstructionIN), .CORE_instr_pc(CORE_instr_pc),
      .CORE_instr_valid(CORE_instr_valid), .IDATA_addr(IDATA_addr), .IDATA_req(IDATA_req),
      .IDATA_gnt(IDATA_gnt), .IDATA_CORE_out(IDATA_CORE_out), .IDATA_rvalid(IDATA_rvalid));

   always #5 clk = ~clk;

   typedef struct {logic [15:0] addr; int due; bit stale;} mreq_t;
   typedef struct {logic [15:0] pc; logic [15:0] data;} ent_t;

   mreq_t       mem_q[$];   // reads accepted by memory, in response order
   ent_t        rq[$];      // instructions the core should see, head first
   logic [15:0] m_fpc;
   int          cyc, lat_lo, lat_hi;
   int          vectors, miscompares;
   logic [55:0] expv;

   function automatic int live_cnt();
      int n = 0;
      foreach (mem_q[i]) if (!mem_q[i].stale) n++;
      return n;
   endfunction

   function automatic logic [55:0] obs();
      return {3'b0, IDATA_req, IDATA_addr, 3'b0, CORE_instr_valid, CORE_InstructionIN, CORE_instr_pc};
   endfunction

   // one cycle: drive inputs at negedge, compute expected outputs, advance the model
   task automatic step(input logic r, input logic [1:0] ctrl, input logic [15:0] tgt, input logic g);
      logic rv, byp, e_req, e_val;
      logic [15:0] d, e_ins, e_pc;
      mreq_t m;
      int due;
      @(negedge clk);
      rst = r; CORE_PC_ctrl = ctrl; CORE_target = tgt; IDATA_gnt = g;
      rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      d  = rv ? (mem_q[0].addr ^ 16'hA5A5) : 16'($urandom);
      IDATA_rvalid = rv; IDATA_CORE_out = d;
      #1;
      e_req = r && !ctrl[1] && ((rq.size() + live_cnt()) < DEPTH);
      byp = 1'b0;
`ifdef NRISC_IFQ_BYPASS_EN
      byp = r && !ctrl[1] && (rq.size() == 0) && rv && !mem_q[0].stale;
`endif
      if (rq.size() > 0) begin e_val = 1'b1; e_ins = rq[0].data; e_pc = rq[0].pc; end
      else if (byp)      begin e_val = 1'b1; e_ins = d; e_pc = mem_q[0].addr; end
      else               begin e_val = 1'b0; e_ins = NOP; e_pc = 16'h0000; end
      expv = {3'b0, e_req, m_fpc, 3'b0, e_val, e_ins, e_pc};
      if (!r) begin
         rq.delete(); mem_q.delete(); m_fpc = RVEC;
      end else begin
         if (rv) m = mem_q.pop_front();
         if (ctrl[1]) begin
            rq.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            m_fpc = ctrl[0] ? RVEC : tgt;
         end else begin
            if (ctrl == 2'b00 && rq.size() > 0) void'(rq.pop_front());
            if (rv && !m.stale && !(byp && ctrl == 2'b00)) rq.push_back('{m.addr, d});
            if (e_req && g) begin
               due = cyc + $urandom_range(lat_hi, lat_lo);
               if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
               mem_q.push_back('{m_fpc, due, 1'b0});
               m_fpc = m_fpc + 16'd1;
            end
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(i == 2, 2'b01, 16'h0, 1'b0);
         vectors++;
         if (obs() !== expv) begin
            miscompares++;
            $display("FAIL reset cyc=%0d got=%h expected=%h", cyc, obs(), expv);
         end
      end
   endtask

   task automatic test_stream();
      lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 2'b00, 16'h0, 1'b1);
         vectors++;
         if (obs() !== expv) begin
            miscompares++;
            $display("FAIL stream cyc=%0d got=%h expected=%h", cyc, obs(), expv);
         end
      end
   endtask

   task automatic test_fill();
      int n_issue = 0;
      lat_lo = 1; lat_hi = 1;
      step(1'b1, 2'b11, 16'h0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 2'b01, 16'h0, 1'b1);
         n_issue += int'(IDATA_req && IDATA_gnt);
         vectors++;
         if (obs() !== expv) begin
            miscompares++;
            $display("FAIL fill cyc=%0d got=%h expected=%h", cyc, obs(), expv);
         end
      end
      vectors++;
      if (n_issue != DEPTH) begin
         miscompares++;
         $display("FAIL fill_count got=%0d expected=%0d", n_issue, DEPTH);
      end
      n_issue = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, (i == 0) ? 2'b00 : 2'b01, 16'h0, 1'b1);
         n_issue += int'(IDATA_req && IDATA_gnt);
      end
      vectors++;
      if (n_issue != 1) begin
         miscompares++;
         $display("FAIL fill_refill got=%0d expected=1", n_issue);
      end
   endtask

   task automatic test_redirect();
      logic seen = 1'b0;
      lat_lo = 3; lat_hi = 3;
      step(1'b1, 2'b11, 16'h0, 1'b0);
      step(1'b1, 2'b01, 16'h0, 1'b1);
      step(1'b1, 2'b01, 16'h0, 1'b1);
      step(1'b1, 2'b10, 16'h0040, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 2'b01, 16'h0, 1'b1);
         vectors++;
         if (obs() !== expv) begin
            miscompares++;
            $display("FAIL redirect cyc=%0d got=%h expected=%h", cyc, obs(), expv);
         end
         if (CORE_instr_valid && !seen) begin
            seen = 1'b1;
            vectors++;
            if (CORE_instr_pc !== 16'h0040) begin
               miscompares++;
               $display("FAIL redirect_head got=%h expected=0040", CORE_instr_pc);
            end
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL redirect_timeout got=no valid head expected=head at 0040");
      end
   endtask

   task automatic test_backpressure();
      logic        stall = 1'b0;
      logic [15:0] paddr = '0;
      lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, ($urandom_range(3, 0) == 0) ? 2'b01 : 2'b00, 16'h0, i[0]);
         vectors++;
         if (obs() !== expv) begin
            miscompares++;
            $display("FAIL backpressure cyc=%0d got=%h expected=%h", cyc, obs(), expv);
         end
         if (stall) begin
            vectors++;
            if (IDATA_addr !== paddr) begin
               miscompares++;
               $display("FAIL addr_stable got=%h expected=%h", IDATA_addr, paddr);
            end
         end
         stall = IDATA_req && !IDATA_gnt;
         paddr = IDATA_addr;
      end
   endtask

   task automatic test_bypass();
      logic seen = 1'b0;
      lat_lo = 1; lat_hi = 1;
      step(1'b1, 2'b10, 16'hB791, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 2'b00, 16'h0, 1'b1);
         vectors++;
         if (obs() !== expv) begin
            miscompares++;
            $display("FAIL bypass cyc=%0d got=%h expected=%h", cyc, obs(), expv);
         end
         if (CORE_instr_valid && !seen) begin
            seen = 1'b1;
            vectors++;
            if ({CORE_InstructionIN, CORE_instr_pc} !== {16'h1234, 16'hB791}) begin
               miscompares++;
               $display("FAIL bypass_first got=%h/%h expected=1234/b791", CORE_InstructionIN, CORE_instr_pc);
            end
         end
      end
   endtask

   task automatic test_random();
      int          sel;
      logic [1:0]  c;
      for (int i = 0; i < 600; i++) begin
         lat_lo = 1; lat_hi = 4;
         sel = $urandom_range(9, 0);
         c = (sel < 5) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
         step($urandom_range(149, 0) != 0, c, 16'($urandom), $urandom_range(2, 0) != 0);
         vectors++;
         if (obs() !== expv) begin
            miscompares++;
            $display("FAIL random cyc=%0d got=%h expected=%h", cyc, obs(), expv);
         end
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0; lat_lo = 1; lat_hi = 1;
      rst = 1'b0; CORE_PC_ctrl = 2'b01; CORE_target = '0;
      IDATA_gnt = 1'b0; IDATA_rvalid = 1'b0; IDATA_CORE_out = '0;
      m_fpc = RVEC;
      repeat (2) @(posedge clk);
      test_reset();
      test_stream();
      test_fill();
      test_redirect();
      test_backpressure();
      test_bypass();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
